// File: rtl/dma_engine_pkg.sv
// Shared DMA types and constants: FSM state encoding, IO window bases
// common with the decoder, and the byte-strobe helper.
package dma_engine_pkg;

  localparam int DATA_W     = 32;
  localparam int STRB_W     = DATA_W / 8;
  localparam int WORD_BYTES = 4;

  localparam logic [31:0] IO0_ADDR = 32'h0004_0000;
  localparam logic [31:0] IO1_ADDR = 32'h0004_2000;
  localparam logic [31:0] IO2_ADDR = 32'h0004_4000;
  localparam logic [31:0] IO3_ADDR = 32'h0004_6000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_DONE
  } dma_state_e;

  // Full word while at least 4 bytes remain; otherwise enable only the low tail lanes.
  function automatic logic [STRB_W-1:0] strb_from_remaining(input logic [31:0] remaining);
    logic [STRB_W-1:0] strb;
    strb = '0;
    if (remaining >= 32'(WORD_BYTES)) begin
      strb = 4'b1111;
    end else begin
      case (remaining[1:0])
        2'd3:    strb = 4'b0111;
        2'd2:    strb = 4'b0011;
        2'd1:    strb = 4'b0001;
        default: strb = 4'b0000;
      endcase
    end
    return strb;
  endfunction

endpackage

// File: rtl/dma_engine_if.sv
// Request/grant read and write bus between the DMA engine (master)
// and the memory/peripheral side (slave).
interface dma_engine_if #(
  parameter int ADDR_W = 32
) ();
  import dma_engine_pkg::*;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              wr_gnt;

  modport master (
    output rd_req, rd_addr,
    input  rd_gnt, rd_valid, rd_data,
    output wr_req, wr_addr, wr_data, wr_strb,
    input  wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr,
    output rd_gnt, rd_valid, rd_data,
    input  wr_req, wr_addr, wr_data, wr_strb,
    output wr_gnt
  );

endinterface

// File: rtl/dma_engine.sv
// Single-channel word-by-word DMA engine: one read, then one write per word,
// with busy held for the whole transfer and a one-cycle done pulse.
module dma_engine
  import dma_engine_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dma_en,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [31:0]       byte_length,
  output logic              dma_busy,
  output logic              dma_done,
  dma_engine_if.master      bus
);

  dma_state_e        state, state_d;
  logic [ADDR_W-1:0] src, src_d;
  logic [ADDR_W-1:0] dst, dst_d;
  logic [LEN_W-1:0]  remaining, remaining_d;
  logic [DATA_W-1:0] buffer, buffer_d;

  logic              rd_req_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              wr_req_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [STRB_W-1:0] wr_strb_q;
  logic              busy_q;
  logic              done_q;

  logic [LEN_W-1:0]  len_in;
  logic              unused_len_hi;

  assign len_in        = byte_length[LEN_W-1:0];
  assign unused_len_hi = ^byte_length[31:LEN_W];

  always_comb begin
    state_d     = state;
    src_d       = src;
    dst_d       = dst;
    remaining_d = remaining;
    buffer_d    = buffer;
    case (state)
      ST_IDLE: begin
        if (dma_en) begin
          src_d       = read_addr;
          dst_d       = write_addr;
          remaining_d = len_in;
          state_d     = (len_in != '0) ? ST_RD_REQ : ST_DONE;
        end
      end
      ST_RD_REQ: begin
        if (bus.rd_gnt) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (bus.rd_valid) begin
          buffer_d = bus.rd_data;
          state_d  = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        if (bus.wr_gnt) begin
          remaining_d = (remaining >= LEN_W'(WORD_BYTES)) ? remaining - LEN_W'(WORD_BYTES) : '0;
          src_d       = src + ADDR_W'(WORD_BYTES);
          dst_d       = dst + ADDR_W'(WORD_BYTES);
          state_d     = (remaining_d == '0) ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      buffer    <= '0;
    end else begin
      state     <= state_d;
      src       <= src_d;
      dst       <= dst_d;
      remaining <= remaining_d;
      buffer    <= buffer_d;
    end
  end

  // Outputs are registered from next-state values so they appear in the
  // first cycle of each state and cannot glitch while waiting for a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_req_q  <= (state_d == ST_RD_REQ);
      rd_addr_q <= (state_d == ST_RD_REQ) ? src_d : '0;
      wr_req_q  <= (state_d == ST_WR_REQ);
      wr_addr_q <= (state_d == ST_WR_REQ) ? dst_d : '0;
      wr_data_q <= (state_d == ST_WR_REQ) ? buffer_d : '0;
      wr_strb_q <= (state_d == ST_WR_REQ) ? strb_from_remaining(32'(remaining_d)) : '0;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign bus.rd_req  = rd_req_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_req  = wr_req_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.wr_strb = wr_strb_q;
  assign dma_busy    = busy_q;
  assign dma_done    = done_q;

endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine with a configurable-latency bus responder.
module tb_dma_engine;
  import dma_engine_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        dma_en;
  logic [31:0] read_addr;
  logic [31:0] write_addr;
  logic [31:0] byte_length;
  logic        dma_busy;
  logic        dma_done;

  dma_engine_if #(.ADDR_W(32)) bus ();

  dma_engine #(.ADDR_W(32), .LEN_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dma_en      (dma_en),
    .read_addr   (read_addr),
    .write_addr  (write_addr),
    .byte_length (byte_length),
    .dma_busy    (dma_busy),
    .dma_done    (dma_done),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Responder: waits are extra cycles beyond the zero-wait behaviour.
  int rd_gnt_dly = 0;
  int rd_val_dly = 0;
  int wr_gnt_dly = 0;
  int rd_cnt = 0;
  int val_cnt = 0;
  int wr_cnt = 0;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_dat = 32'h0;

  assign bus.rd_gnt   = bus.rd_req && (rd_cnt >= rd_gnt_dly);
  assign bus.rd_valid = rd_pend && (val_cnt >= rd_val_dly);
  assign bus.rd_data  = bus.rd_valid ? rd_dat : 32'hDEAD_BEEF;
  assign bus.wr_gnt   = bus.wr_req && (wr_cnt >= wr_gnt_dly);

  always @(posedge clk) begin
    rd_cnt <= (bus.rd_req && !bus.rd_gnt) ? rd_cnt + 1 : 0;
    wr_cnt <= (bus.wr_req && !bus.wr_gnt) ? wr_cnt + 1 : 0;
    if (bus.rd_req && bus.rd_gnt) begin
      rd_pend <= 1'b1;
      val_cnt <= 0;
      rd_dat  <= bus.rd_addr + 32'h1111_0000;
    end else if (bus.rd_valid) begin
      rd_pend <= 1'b0;
    end else if (rd_pend) begin
      val_cnt <= val_cnt + 1;
    end
  end

  // Transaction log and request-stability monitor.
  logic        log_clr = 1'b0;
  logic [31:0] rd_log [8];
  logic [31:0] wa_log [8];
  logic [31:0] wd_log [8];
  logic [3:0]  ws_log [8];
  int rd_n = 0;
  int wr_n = 0;
  int done_n = 0;
  int stab_err = 0;
  logic        rd_hold = 1'b0;
  logic        wr_hold = 1'b0;
  logic [31:0] prev_ra = 32'h0;
  logic [31:0] prev_wa = 32'h0;
  logic [31:0] prev_wd = 32'h0;
  logic [3:0]  prev_ws = 4'h0;

  always @(posedge clk) begin
    if (log_clr) begin
      rd_n     <= 0;
      wr_n     <= 0;
      done_n   <= 0;
      stab_err <= 0;
    end else begin
      if (bus.rd_req && bus.rd_gnt) begin
        if (rd_n < 8) rd_log[rd_n[2:0]] <= bus.rd_addr;
        rd_n <= rd_n + 1;
      end
      if (bus.wr_req && bus.wr_gnt) begin
        if (wr_n < 8) begin
          wa_log[wr_n[2:0]] <= bus.wr_addr;
          wd_log[wr_n[2:0]] <= bus.wr_data;
          ws_log[wr_n[2:0]] <= bus.wr_strb;
        end
        wr_n <= wr_n + 1;
      end
      if (dma_done) done_n <= done_n + 1;
      if (rd_hold && rst_n && (!bus.rd_req || bus.rd_addr != prev_ra)) stab_err <= stab_err + 1;
      if (wr_hold && rst_n && (!bus.wr_req || bus.wr_addr != prev_wa ||
                               bus.wr_data != prev_wd || bus.wr_strb != prev_ws))
        stab_err <= stab_err + 1;
    end
    rd_hold <= bus.rd_req && !bus.rd_gnt;
    wr_hold <= bus.wr_req && !bus.wr_gnt;
    prev_ra <= bus.rd_addr;
    prev_wa <= bus.wr_addr;
    prev_wd <= bus.wr_data;
    prev_ws <= bus.wr_strb;
  end

  // Issue one instruction in cycle 0, optionally pulse a second dma_en in
  // cycle pulse_cyc, and report the cycle dma_done was seen and busy cycles.
  task automatic run(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                     input int pulse_cyc, output int done_cyc, output int busy_cyc);
    @(negedge clk);
    dma_en      = 1'b1;
    read_addr   = src;
    write_addr  = dst;
    byte_length = len;
    log_clr     = 1'b1;
    done_cyc    = -1;
    busy_cyc    = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      log_clr = 1'b0;
      if (c == pulse_cyc) begin
        dma_en      = 1'b1;
        read_addr   = IO3_ADDR;
        write_addr  = 32'h0030_0000;
        byte_length = 32'd4;
      end else begin
        dma_en = 1'b0;
      end
      if (dma_busy) busy_cyc++;
      if (dma_done && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0 && !dma_busy && c > pulse_cyc) break;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({dma_busy, dma_done, bus.rd_req, bus.wr_req} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/rd_req/wr_req=%b required 0000",
               {dma_busy, dma_done, bus.rd_req, bus.wr_req});
    end
    checks++;
    if ({bus.rd_addr, bus.wr_addr, bus.wr_data, bus.wr_strb} !== 100'h0) begin
      errors++;
      $display("FAIL reset_bus: rd_addr=%h wr_addr=%h wr_data=%h wr_strb=%b required all 0",
               bus.rd_addr, bus.wr_addr, bus.wr_data, bus.wr_strb);
    end
  endtask

  task automatic test_len8();
    int dc, bc;
    run(IO0_ADDR, 32'h0012_0000, 32'd8, 0, dc, bc);
    checks++;
    if (dc !== 7) begin errors++; $display("FAIL len8_done_cycle: got %0d required 7", dc); end
    checks++;
    if (bc !== 7) begin errors++; $display("FAIL len8_busy_cycles: got %0d required 7", bc); end
    checks++;
    if (rd_n !== 2 || rd_log[0] !== 32'h0004_0000 || rd_log[1] !== 32'h0004_0004) begin
      errors++;
      $display("FAIL len8_reads: n=%0d %h %h required 2 00040000 00040004", rd_n, rd_log[0], rd_log[1]);
    end
    checks++;
    if (wr_n !== 2 || wa_log[0] !== 32'h0012_0000 || wa_log[1] !== 32'h0012_0004) begin
      errors++;
      $display("FAIL len8_wr_addr: n=%0d %h %h required 2 00120000 00120004", wr_n, wa_log[0], wa_log[1]);
    end
    checks++;
    if (wd_log[0] !== 32'h1115_0000 || wd_log[1] !== 32'h1115_0004 ||
        ws_log[0] !== 4'b1111 || ws_log[1] !== 4'b1111) begin
      errors++;
      $display("FAIL len8_wr_data: %h/%b %h/%b required 11150000/1111 11150004/1111",
               wd_log[0], ws_log[0], wd_log[1], ws_log[1]);
    end
    checks++;
    if (done_n !== 1) begin errors++; $display("FAIL len8_done_pulses: got %0d required 1", done_n); end
  endtask

  task automatic test_tail();
    int dc, bc;
    run(IO1_ADDR, 32'h0013_0000, 32'd6, 0, dc, bc);
    checks++;
    if (dc !== 7) begin errors++; $display("FAIL len6_done_cycle: got %0d required 7", dc); end
    checks++;
    if (wr_n !== 2 || ws_log[0] !== 4'b1111 || ws_log[1] !== 4'b0011 || wd_log[1] !== 32'h1115_2004) begin
      errors++;
      $display("FAIL len6_tail: n=%0d strb %b %b data1 %h required 2 1111 0011 11152004",
               wr_n, ws_log[0], ws_log[1], wd_log[1]);
    end
    // Bits above LEN_W are ignored: 0x41 is a 1-byte transfer.
    run(IO2_ADDR, 32'h0014_0000, 32'h0000_0041, 0, dc, bc);
    checks++;
    if (dc !== 4) begin errors++; $display("FAIL len1_done_cycle: got %0d required 4", dc); end
    checks++;
    if (wr_n !== 1 || ws_log[0] !== 4'b0001 || wa_log[0] !== 32'h0014_0000 || wd_log[0] !== 32'h1115_4000) begin
      errors++;
      $display("FAIL len1_write: n=%0d strb %b addr %h data %h required 1 0001 00140000 11154000",
               wr_n, ws_log[0], wa_log[0], wd_log[0]);
    end
  endtask

  task automatic test_zero_len();
    int dc, bc;
    run(IO0_ADDR, 32'h0015_0000, 32'd0, 0, dc, bc);
    checks++;
    if (dc !== 1) begin errors++; $display("FAIL len0_done_cycle: got %0d required 1", dc); end
    checks++;
    if (bc !== 1) begin errors++; $display("FAIL len0_busy_cycles: got %0d required 1", bc); end
    checks++;
    if (rd_n !== 0 || wr_n !== 0) begin
      errors++;
      $display("FAIL len0_bus_idle: reads=%0d writes=%0d required 0 0", rd_n, wr_n);
    end
  endtask

  task automatic test_backpressure();
    int dc, bc;
    rd_gnt_dly = 3; rd_val_dly = 2; wr_gnt_dly = 2;
    run(IO0_ADDR, 32'h0012_0000, 32'd8, 0, dc, bc);
    rd_gnt_dly = 0; rd_val_dly = 0; wr_gnt_dly = 0;
    checks++;
    if (dc !== 21) begin errors++; $display("FAIL bp_done_cycle: got %0d required 21", dc); end
    checks++;
    if (stab_err !== 0) begin errors++; $display("FAIL bp_stability: got %0d changes required 0", stab_err); end
    checks++;
    if (rd_log[1] !== 32'h0004_0004 || wa_log[1] !== 32'h0012_0004 || wd_log[1] !== 32'h1115_0004) begin
      errors++;
      $display("FAIL bp_second_word: rd %h wa %h wd %h required 00040004 00120004 11150004",
               rd_log[1], wa_log[1], wd_log[1]);
    end
  endtask

  task automatic test_en_while_busy();
    int dc, bc;
    rd_val_dly = 2;
    run(IO0_ADDR, 32'h0012_0000, 32'd8, 2, dc, bc);
    rd_val_dly = 0;
    checks++;
    if (dc !== 11) begin errors++; $display("FAIL busy_en_done_cycle: got %0d required 11", dc); end
    checks++;
    if (done_n !== 1 || rd_n !== 2 || wr_n !== 2) begin
      errors++;
      $display("FAIL busy_en_counts: done=%0d rd=%0d wr=%0d required 1 2 2", done_n, rd_n, wr_n);
    end
    checks++;
    if (rd_log[1] !== 32'h0004_0004 || wa_log[0] !== 32'h0012_0000 || wa_log[1] !== 32'h0012_0004) begin
      errors++;
      $display("FAIL busy_en_addrs: rd1 %h wa0 %h wa1 %h required 00040004 00120000 00120004",
               rd_log[1], wa_log[0], wa_log[1]);
    end
  endtask

  task automatic test_reset_mid();
    int dc, bc;
    rd_val_dly = 2;
    @(negedge clk);
    dma_en = 1'b1; read_addr = IO0_ADDR; write_addr = 32'h0012_0000; byte_length = 32'd8;
    log_clr = 1'b1;
    @(negedge clk);
    dma_en = 1'b0; log_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dma_busy, dma_done, bus.rd_req, bus.wr_req} !== 4'b0000 ||
        {bus.rd_addr, bus.wr_addr, bus.wr_data, bus.wr_strb} !== 100'h0) begin
      errors++;
      $display("FAIL midreset_outputs: busy=%b done=%b rd_req=%b wr_req=%b rd_addr=%h required all 0",
               dma_busy, dma_done, bus.rd_req, bus.wr_req, bus.rd_addr);
    end
    repeat (3) @(negedge clk);
    rd_val_dly = 0;
    checks++;
    if (done_n !== 0 || wr_n !== 0) begin
      errors++;
      $display("FAIL midreset_abort: done=%0d writes=%0d required 0 0", done_n, wr_n);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(IO1_ADDR, 32'h0020_0000, 32'd4, 0, dc, bc);
    checks++;
    if (dc !== 4) begin errors++; $display("FAIL post_reset_done_cycle: got %0d required 4", dc); end
    checks++;
    if (wr_n !== 1 || wa_log[0] !== 32'h0020_0000 || wd_log[0] !== 32'h1115_2000 || ws_log[0] !== 4'b1111) begin
      errors++;
      $display("FAIL post_reset_write: n=%0d %h %h %b required 1 00200000 11152000 1111",
               wr_n, wa_log[0], wd_log[0], ws_log[0]);
    end
  endtask

  task automatic test_wrap();
    int dc, bc;
    run(32'hFFFF_FFFC, 32'h0001_0000, 32'd8, 0, dc, bc);
    checks++;
    if (rd_n !== 2 || rd_log[0] !== 32'hFFFF_FFFC || rd_log[1] !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_reads: n=%0d %h %h required 2 fffffffc 00000000", rd_n, rd_log[0], rd_log[1]);
    end
    checks++;
    if (wd_log[0] !== 32'h1110_FFFC || wd_log[1] !== 32'h1111_0000 || dc !== 7) begin
      errors++;
      $display("FAIL wrap_data: %h %h done %0d required 1110fffc 11110000 7", wd_log[0], wd_log[1], dc);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    dma_en = 1'b0;
    read_addr = 32'h0;
    write_addr = 32'h0;
    byte_length = 32'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_len8();
    test_tail();
    test_zero_len();
    test_backpressure();
    test_en_while_busy();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_engine.md
# dma_engine

Single-channel DMA engine sitting directly downstream of the instruction decoder. It accepts one decoded DMA instruction (enable, source, destination, byte count) and moves the data word by word from source to destination over a simple request/grant bus. While it runs it holds `dma_busy` so the issue/scoreboard logic stalls. It reports completion with a one-cycle `dma_done` pulse.

## Interface
Parameters:
- `ADDR_W`, 32: address width; address arithmetic is modulo 2^ADDR_W.
- `LEN_W`, 6: number of significant bits of `byte_length` (max 63 bytes).

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dma_en`  in  1  decoded DMA instruction valid; sampled only in IDLE.
- `read_addr`  in  ADDR_W  source start address, word-aligned.
- `write_addr`  in  ADDR_W  destination start address, word-aligned.
- `byte_length`  in  32  transfer length; bits above LEN_W-1 ignored.
- `dma_busy`  out  1  high in every state except IDLE.
- `dma_done`  out  1  one-cycle completion pulse.
- `rd_req`  out  1  bus read request.
- `rd_addr`  out  ADDR_W  read address, stable while `rd_req`=1.
- `rd_gnt`  in  1  read request accepted.
- `rd_valid`  in  1  read data valid.
- `rd_data`  in  32  read data.
- `wr_req`  out  1  bus write request.
- `wr_addr`  out  ADDR_W  write address.
- `wr_data`  out  32  write data.
- `wr_strb`  out  4  byte enables, bit i = byte lane i (little-endian).
- `wr_gnt`  in  1  write accepted.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE: on `dma_en`=1, latch src, dst, and `remaining = byte_length[LEN_W-1:0]`. Go to RD_REQ if `remaining` != 0, else DONE.
- RD_REQ: `rd_req`=1, `rd_addr`=src. On `rd_gnt`, go to RD_WAIT.
- RD_WAIT: on `rd_valid`, capture `rd_data` into the word buffer and go to WR_REQ. `rd_valid` is sampled only in this state.
- WR_REQ: `wr_req`=1, `wr_addr`=dst, `wr_data`=buffer. `wr_strb` is 1111 if `remaining`≥4, else 0111/0011/0001 for 3/2/1.
  - On `wr_gnt`: `remaining -= min(4, remaining)`, src += 4, dst += 4.
  - Go to DONE if the new `remaining` is 0, else RD_REQ.
- DONE: `dma_done`=1 for one cycle, then IDLE.
- At most one outstanding read. Reads are full words; tail bytes beyond the length are discarded through `wr_strb`.
- `dma_en` while busy is ignored, and no state is corrupted. Upstream must stall on `dma_busy`.

## Timing
- Reset values: all outputs 0. State is IDLE, buffer and counters are 0.
- Reset asserted mid-transfer aborts immediately: no further requests and no `dma_done`. A new `dma_en` is accepted in the first cycle after release.
- Request outputs are registered and held stable until granted. Grants may arrive in the same cycle the request is first asserted.
- Zero-wait bus (`rd_gnt` same cycle, `rd_valid` the next cycle, `wr_gnt` same cycle): 3 cycles per word.
  - `dma_en` is sampled in cycle 0.
  - `dma_done` is high in cycle 3·N+1, where N = ceil(len/4).
  - Zero length: `dma_done` in cycle 1, with no bus activity.
- `dma_busy` rises in cycle 1, stays high through the DONE cycle, and is low the cycle after.
- Address increment wraps at 2^ADDR_W with no error.

## Structure
- Shared package holds:
  - the state enum (IDLE..DONE);
  - the IO base constants IO0_ADDR=0x00040000, IO1_ADDR=0x00042000, IO2_ADDR=0x00044000, IO3_ADDR=0x00046000, shared with the decoder;
  - a strobe-from-remaining function.
- Single module. No sub-module is required; the strobe generator stays a package function.

## Test plan
- Length 8, src 0x00040000, dst 0x00120000, zero-wait bus:
  - reads at 0x00040000 and 0x00040004;
  - writes at 0x00120000 and 0x00120004 with strb 1111 and matching data;
  - `dma_done` in cycle 7.
- Length 6: second write has strb 0011 and `dma_done` is in cycle 7. Length 1: single write with strb 0001 and `dma_done` in cycle 4.
- Length 0: no `rd_req`/`wr_req`, `dma_done` in cycle 1, `dma_busy` high for exactly 1 cycle.
- Backpressure: `rd_gnt` delayed 3 cycles, `rd_valid` 2 cycles later, `wr_gnt` delayed 2 cycles.
  - `rd_addr`/`wr_addr`/`wr_data` stay stable throughout.
  - `dma_done` is delayed by exactly the inserted waits.
- `dma_en` pulsed during RD_WAIT with different addresses: the transfer is unaffected. Reset asserted in RD_WAIT: all outputs 0 at once, no `dma_done`, and the next `dma_en` is accepted.
- src 0xFFFFFFFC, length 8: second read at 0x00000000.
